seq_booth_mul: RTL and testbench
================================

// Module: seq_booth_mul
// PURPOSE
//  Multi-cycle, parametrised radix-2 Booth multiplier for the ALU datapath. It replaces the
//  combinational 8-bit multiply with a clocked START/DONE unit that returns the full
//  2*WIDTH-bit product. It supports signed and unsigned operands and flags products that
//  do not fit back into WIDTH bits. It sits beside the add/and/or/shift units under ALU control.
// PARAMETERS
//  WIDTH  8  operand width in bits; product is 2*WIDTH bits; legal range 4..32
// PORTS
//  CLK          in   1          clock; all state changes on rising edge
//  RESET        in   1          asynchronous, active-high reset
//  START        in   1          request; sampled only when BUSY=0
//  SIGNED_MODE  in   1          1: two's-complement operands, 0: unsigned
//  DATA1        in   WIDTH      multiplicand, captured with START
//  DATA2        in   WIDTH      multiplier, captured with START
//  BUSY         out  1          high while an operation is in progress
//  DONE         out  1          one-cycle pulse when RESULT/OVERFLOW become valid
//  RESULT       out  2*WIDTH    product; held until the next completion
//  OVERFLOW     out  1          product not representable in WIDTH bits (per mode)
// BEHAVIOUR
//  - Reset: RESULT=0, OVERFLOW=0, DONE=0, BUSY=0, state=IDLE. Reset takes effect
//    asynchronously, also mid-operation; the operation in flight is discarded.
//  - FSM states: IDLE, RUN, FIN. Operands are registered; there are no # delays in this block.
//  - IDLE: START=1 at an edge -> capture M={SIGNED_MODE&DATA1[W-1],DATA1} and
//    Q={SIGNED_MODE&DATA2[W-1],DATA2} (W+1 bits each); P={0(W+2 bits),Q,1'b0};
//    cnt=0; state goes to RUN.
//  - RUN: exactly one Booth step per edge. Step = inspect P[1:0]: 01 -> add M, 10 -> subtract M,
//    else no add. The add/sub applies to the W+2-bit accumulator, sign-extended M.
//    The step then arithmetic-right-shifts the whole of P by 1. A step is applied while
//    cnt<W+1 (W+1 steps in total).
//  - The edge performing step W+1 also loads RESULT=product[2W-1:0] and OVERFLOW,
//    sets DONE=1, and moves state to FIN.
//  - FIN: lasts one cycle, then state goes to IDLE. START at the FIN edge is accepted
//    (back-to-back, same capture as IDLE).
//  - Latency: START sampled at edge k -> DONE high in the cycle after edge k+W+1
//    (9 cycles for W=8). Throughput is one operation per W+2 cycles.
//  - BUSY=1 in RUN only; BUSY=0 in IDLE and FIN. START while BUSY=1 is ignored, and
//    DATA1/DATA2/SIGNED_MODE changes while BUSY=1 have no effect.
//  - DONE is high for exactly one cycle per accepted START, never otherwise.
//  - RESULT/OVERFLOW change only on the completing edge or on reset.
//  - OVERFLOW, signed: RESULT[2W-1:W-1] not all-equal. Unsigned: RESULT[2W-1:W]!=0.
//  - Boundary values are exact: most-negative*most-negative, 0*x, (2^W-1)^2 unsigned.
//    The W+1-bit extension plus W+2-bit accumulator guarantees this.
// STRUCTURE
//  - Shared package/include alu_defs: FSM state encodings (IDLE/RUN/FIN) and
//    mode constants (MUL_SIGNED=1, MUL_UNSIGNED=0), shared with the ALU controller.
//  - One sub-module, booth_step (combinational, parametrised on WIDTH): takes P and M and
//    returns the next P (add/sub + arithmetic shift). The top holds the FSM, counter and
//    registers; the counter width is $clog2(WIDTH+2).
// TESTING (WIDTH=8 unless noted)
//  1. SIGNED=1, DATA1=8'hFD, DATA2=8'h05, START 1 cycle -> DONE 9 cycles later,
//     RESULT=16'hFFF1, OVERFLOW=0, BUSY high for 9 cycles.
//  2. SIGNED=0, 8'hFF*8'hFF -> RESULT=16'hFE01, OVERFLOW=1. SIGNED=1, same operands
//     -> RESULT=16'h0001, OVERFLOW=0.
//  3. SIGNED=1, 8'h80*8'h80 -> 16'h4000, OVERFLOW=1. 8'h7F*8'hFF -> 16'hFF81,
//     OVERFLOW=0. 8'h00*8'h9C -> 16'h0000.
//  4. Re-pulse START with new operands at cycles 2 and 5 of RUN -> ignored; single DONE,
//     first result. START at the FIN edge -> second op accepted, second DONE 10 cycles
//     after the first.
//  5. RESET asserted at cycle 4 of RUN (between edges) -> BUSY/DONE/RESULT/OVERFLOW=0
//     immediately, no DONE. After release, 8'h0C*8'h0B unsigned -> 16'h0084.
//  6. WIDTH=16 random sweep, both modes, vs. a reference model -> all RESULT/OVERFLOW
//     match; DONE exactly 17 cycles after each START.

Source files
------------

// File: rtl/alu_defs_pkg.sv
// Shared ALU definitions: multiplier FSM state encodings and
// multiply mode constants, also used by the ALU controller.
package alu_defs;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    localparam logic MUL_SIGNED   = 1'b1;
    localparam logic MUL_UNSIGNED = 1'b0;

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth iteration: add/subtract M into the accumulator
// selected by P[1:0], then arithmetic right shift of all of P.
// Ports:
//   p       : in  current partial-product register {acc, q, q_-1}
//   m       : in  sign-extended multiplicand (WIDTH+1 bits)
//   p_next  : out P after the step
//   product : out low 2*WIDTH product bits taken from p_next
module booth_step #(
    parameter int WIDTH = 8
) (
    input  logic [2*WIDTH+3:0] p,
    input  logic [WIDTH:0]     m,
    output logic [2*WIDTH+3:0] p_next,
    output logic [2*WIDTH-1:0] product
);

    localparam int PW = 2 * WIDTH + 4;

    logic [WIDTH+1:0] acc;
    logic [WIDTH+1:0] mext;
    logic [WIDTH+1:0] sum;

    always_comb begin
        acc  = p[PW-1:WIDTH+2];
        mext = {m[WIDTH], m};
        case (p[1:0])
            2'b01:   sum = acc + mext;
            2'b10:   sum = acc - mext;
            default: sum = acc;
        endcase
        // shift {sum, q, q_-1} right by one, replicating the sign
        p_next  = {sum[WIDTH+1], sum, p[WIDTH+1:1]};
        // after the last step {acc, q} holds the full product
        product = p_next[2*WIDTH:1];
    end

endmodule

// File: rtl/seq_booth_mul.sv
// Sequential radix-2 Booth multiplier with START/DONE handshake.
// Ports:
//   CLK, RESET (async, active high)
//   START, SIGNED_MODE, DATA1 (multiplicand), DATA2 (multiplier)
//   BUSY (RUN state), DONE (one-cycle pulse in FIN)
//   RESULT (2*WIDTH product), OVERFLOW (product exceeds WIDTH bits)
module seq_booth_mul
    import alu_defs::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               START,
    input  logic               SIGNED_MODE,
    input  logic [WIDTH-1:0]   DATA1,
    input  logic [WIDTH-1:0]   DATA2,
    output logic               BUSY,
    output logic               DONE,
    output logic [2*WIDTH-1:0] RESULT,
    output logic               OVERFLOW
);

    localparam int PW = 2 * WIDTH + 4;
    localparam int CW = $clog2(WIDTH + 2);

    state_t state;
    state_t state_next;

    logic             capture;
    logic             last_step;
    logic             mode_q;
    logic [WIDTH:0]   m_q;
    logic [PW-1:0]    p_q;
    logic [PW-1:0]    p_next;
    logic [CW-1:0]    cnt;
    logic [2*WIDTH-1:0] product;
    logic             ovf_next;

    booth_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .p       (p_q),
        .m       (m_q),
        .p_next  (p_next),
        .product (product)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        capture    = 1'b0;
        last_step  = 1'b0;
        BUSY       = 1'b0;
        DONE       = 1'b0;
        case (state)
            IDLE: begin
                if (START) begin
                    capture    = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                BUSY = 1'b1;
                if (cnt == CW'(WIDTH)) begin
                    last_step  = 1'b1;
                    state_next = FIN;
                end
            end
            FIN: begin
                DONE = 1'b1;
                if (START) begin
                    capture    = 1'b1;
                    state_next = RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // signed: top WIDTH+1 bits must all equal the sign
    always_comb begin
        if (mode_q == MUL_SIGNED)
            ovf_next = !((&product[2*WIDTH-1:WIDTH-1]) ||
                         !(|product[2*WIDTH-1:WIDTH-1]));
        else
            ovf_next = |product[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            m_q      <= '0;
            p_q      <= '0;
            cnt      <= '0;
            mode_q   <= 1'b0;
            RESULT   <= '0;
            OVERFLOW <= 1'b0;
        end else if (capture) begin
            m_q    <= {SIGNED_MODE & DATA1[WIDTH-1], DATA1};
            p_q    <= {{(WIDTH + 2){1'b0}},
                       SIGNED_MODE & DATA2[WIDTH-1],
                       DATA2, 1'b0};
            cnt    <= '0;
            mode_q <= SIGNED_MODE;
        end else if (state == RUN) begin
            p_q <= p_next;
            cnt <= cnt + CW'(1);
            if (last_step) begin
                RESULT   <= product;
                OVERFLOW <= ovf_next;
            end
        end
    end

endmodule

// File: tb/tb_seq_booth_mul.sv
// Directed self-checking bench for seq_booth_mul (WIDTH=8 and 16).
// Expected values are hand-computed products.
module tb_seq_booth_mul;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        smode = 1'b0;
    logic [7:0]  d1 = '0;
    logic [7:0]  d2 = '0;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic        ovf;

    logic        start16 = 1'b0;
    logic        smode16 = 1'b0;
    logic [15:0] a16 = '0;
    logic [15:0] b16 = '0;
    logic        busy16;
    logic        done16;
    logic [31:0] res16;
    logic        ovf16;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic        s;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] r;
        logic        o;
    } vec8_t;

    typedef struct {
        logic        s;
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] r;
        logic        o;
    } vec16_t;

    always #5 clk = ~clk;

    seq_booth_mul #(.WIDTH(8)) dut (
        .CLK         (clk),
        .RESET       (rst),
        .START       (start),
        .SIGNED_MODE (smode),
        .DATA1       (d1),
        .DATA2       (d2),
        .BUSY        (busy),
        .DONE        (done),
        .RESULT      (result),
        .OVERFLOW    (ovf)
    );

    seq_booth_mul #(.WIDTH(16)) dut16 (
        .CLK         (clk),
        .RESET       (rst),
        .START       (start16),
        .SIGNED_MODE (smode16),
        .DATA1       (a16),
        .DATA2       (b16),
        .BUSY        (busy16),
        .DONE        (done16),
        .RESULT      (res16),
        .OVERFLOW    (ovf16)
    );

    // Pulse START for one edge, then scramble inputs while busy.
    task automatic run8(input logic s, input logic [7:0] a,
                        input logic [7:0] b,
                        output int lat, output int bcnt);
        @(negedge clk);
        smode = s; d1 = a; d2 = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0; smode = ~s; d1 = 8'h5A; d2 = 8'hA5;
        lat = 0;
        bcnt = busy ? 1 : 0;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
            if (busy) bcnt++;
        end
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({busy, done, result, ovf} !== 19'd0) begin
            failures++;
            $display("FAIL reset_state got b=%b d=%b r=%h o=%b want 0",
                     busy, done, result, ovf);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_signed_basic();
        int lat, bc;
        run8(1'b1, 8'hFD, 8'h05, lat, bc);
        checks++;
        if (lat !== 9) begin
            failures++;
            $display("FAIL t1_latency got %0d want 9", lat);
        end
        checks++;
        if (bc !== 9) begin
            failures++;
            $display("FAIL t1_busy_cycles got %0d want 9", bc);
        end
        checks++;
        if (result !== 16'hFFF1 || ovf !== 1'b0) begin
            failures++;
            $display("FAIL t1_result got %h/%b want fff1/0", result, ovf);
        end
    endtask

    task automatic test_boundaries();
        vec8_t t[5];
        int lat, bc;
        t[0] = '{1'b0, 8'hFF, 8'hFF, 16'hFE01, 1'b1};
        t[1] = '{1'b1, 8'hFF, 8'hFF, 16'h0001, 1'b0};
        t[2] = '{1'b1, 8'h80, 8'h80, 16'h4000, 1'b1};
        t[3] = '{1'b1, 8'h7F, 8'hFF, 16'hFF81, 1'b0};
        t[4] = '{1'b1, 8'h00, 8'h9C, 16'h0000, 1'b0};
        for (int i = 0; i < 5; i++) begin
            run8(t[i].s, t[i].a, t[i].b, lat, bc);
            checks++;
            if (lat !== 9 || result !== t[i].r || ovf !== t[i].o) begin
                failures++;
                $display("FAIL bound_%0d got lat=%0d %h/%b want 9 %h/%b",
                         i, lat, result, ovf, t[i].r, t[i].o);
            end
        end
    endtask

    task automatic test_back_to_back();
        int n, m, first_n, dones;
        @(negedge clk);
        smode = 1'b0; d1 = 8'h12; d2 = 8'h34; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0; first_n = 0; dones = 0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
            start = (n == 2 || n == 5);
            if (start) begin
                smode = 1'b1; d1 = 8'hFF; d2 = 8'hFF;
            end
            if (done) begin
                dones++;
                if (first_n == 0) first_n = n;
            end
        end
        checks++;
        if (first_n !== 9 || dones !== 1) begin
            failures++;
            $display("FAIL t4_first_done got n=%0d cnt=%0d want 9/1",
                     first_n, dones);
        end
        checks++;
        if (result !== 16'h03A8 || ovf !== 1'b1) begin
            failures++;
            $display("FAIL t4_first_result got %h/%b want 03a8/1",
                     result, ovf);
        end
        smode = 1'b1; d1 = 8'h9C; d2 = 8'h03; start = 1'b1;
        m = 0;
        do begin
            @(negedge clk);
            m++;
            start = 1'b0;
        end while (!done && m < 40);
        checks++;
        if (m !== 10) begin
            failures++;
            $display("FAIL t4_second_gap got %0d want 10", m);
        end
        checks++;
        if (result !== 16'hFED4 || ovf !== 1'b1) begin
            failures++;
            $display("FAIL t4_second_result got %h/%b want fed4/1",
                     result, ovf);
        end
    endtask

    task automatic test_reset_midrun();
        int stray, lat, bc;
        @(negedge clk);
        smode = 1'b1; d1 = 8'h80; d2 = 8'h80; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, result, ovf} !== 19'd0) begin
            failures++;
            $display("FAIL t5_async_reset got b=%b d=%b r=%h o=%b want 0",
                     busy, done, result, ovf);
        end
        @(negedge clk);
        rst = 1'b0;
        stray = 0;
        repeat (15) begin
            @(negedge clk);
            if (done) stray++;
        end
        checks++;
        if (stray !== 0) begin
            failures++;
            $display("FAIL t5_no_done got %0d pulses want 0", stray);
        end
        run8(1'b0, 8'h0C, 8'h0B, lat, bc);
        checks++;
        if (lat !== 9 || result !== 16'h0084 || ovf !== 1'b0) begin
            failures++;
            $display("FAIL t5_after got lat=%0d %h/%b want 9 0084/0",
                     lat, result, ovf);
        end
    endtask

    task automatic test_wide16();
        vec16_t t[6];
        int lat;
        t[0] = '{1'b1, 16'h8000, 16'h8000, 32'h40000000, 1'b1};
        t[1] = '{1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001, 1'b1};
        t[2] = '{1'b0, 16'h1234, 16'h0010, 32'h00012340, 1'b1};
        t[3] = '{1'b0, 16'h0100, 16'h00FF, 32'h0000FF00, 1'b0};
        t[4] = '{1'b1, 16'hFFFE, 16'h0003, 32'hFFFFFFFA, 1'b0};
        t[5] = '{1'b1, 16'h7FFF, 16'h0002, 32'h0000FFFE, 1'b1};
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            smode16 = t[i].s; a16 = t[i].a; b16 = t[i].b;
            start16 = 1'b1;
            @(negedge clk);
            start16 = 1'b0; a16 = 16'hDEAD; b16 = 16'hBEEF;
            lat = 0;
            while (!done16 && lat < 60) begin
                @(negedge clk);
                lat++;
            end
            checks++;
            if (lat !== 17 || res16 !== t[i].r || ovf16 !== t[i].o) begin
                failures++;
                $display("FAIL w16_%0d got lat=%0d %h/%b want 17 %h/%b",
                         i, lat, res16, ovf16, t[i].r, t[i].o);
            end
        end
    endtask

    initial begin
        test_reset();
        test_signed_basic();
        test_boundaries();
        test_back_to_back();
        test_reset_midrun();
        test_wide16();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
